alu_shift_unit: RTL and testbench
=================================

// Module: alu_shift_unit
// PURPOSE
//  Parametrised multi-cycle shifter for the CPU ALU datapath. It is the
//  successor to the single-cycle combinational/registered SLL/SRA shifter.
//  - Width is generic; the bits shifted per cycle (STEP) are selectable,
//    from 1-bit serial up to a full barrel shifter.
//  - Adds a rotate-right op, a valid/ready handshake on both sides, a flush
//    input and a zero flag.
//  - Sits beside the add/compare logic; the core issues one shift and
//    stalls on in_ready/out_valid.
// PARAMETERS
//  XLEN     32            datapath width; power of two, >= 8
//  SHAMT_W  $clog2(XLEN)  shift-amount width (derived; do not override)
//  STEP     4             max bits shifted per cycle; power of two, 1..XLEN
//                         (STEP == XLEN gives a barrel shifter)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous reset, active-high
//  in_valid   in   1        request valid
//  in_ready   out  1        unit can accept a request this cycle
//  in_op      in   2        shift_pkg::shift_op_e: SLL=0 SRL=1 SRA=2 ROR=3
//  in_data    in   XLEN     operand to shift
//  in_shamt   in   SHAMT_W  shift amount
//  flush      in   1        synchronous abort of any in-flight op
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer takes the result
//  out_data   out  XLEN     shifted result
//  out_zero   out  1        out_data == 0, valid while out_valid
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, any time, including mid-operation):
//   - state=IDLE; out_valid=0, out_data=0, out_zero=0, busy=0.
//   - Internal op, count and data registers are cleared.
//   - in_ready=1 after reset deasserts.
//  FSM states: IDLE, SHIFT, DONE.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready).
//   - Accept = in_valid & in_ready. On accept: capture in_data, in_shamt
//     into cnt, and in_op; next state = SHIFT.
//   - SHIFT, each cycle: amt = min(cnt, STEP); apply amt to data;
//     cnt -= amt. If cnt <= STEP, the final amt is applied this cycle and
//     next state = DONE.
//   - DONE: out_valid=1; out_data and out_zero stay stable until out_ready.
//     - out_ready without accept -> IDLE.
//     - out_ready with a simultaneous accept -> SHIFT with the new
//       request. Back-to-back issue loses no cycle.
//   - Without out_ready, the unit stays in DONE and in_ready=0
//     (backpressure holds the result).
//  Latency: out_valid rises L = 1 + max(1, ceil(shamt/STEP)) rising edges
//  after the accept edge.
//   - shamt=0 -> L=2, result = operand unchanged.
//   - STEP==XLEN -> L=2 for every shamt.
//  Op semantics per step of amt bits:
//   - SLL: zero fill from the LSB side.
//   - SRL: zero fill from the MSB side.
//   - SRA: fill with bit XLEN-1 of the captured operand; the sign is held
//     through all steps.
//   - ROR: bits leaving at bit 0 re-enter at bit XLEN-1; multi-step
//     rotation equals a single rotate by shamt.
//   - All arithmetic is mod XLEN; no shamt value is illegal.
//  Flush:
//   - Takes priority over every transition: next state=IDLE,
//     out_valid=0 next cycle, any pending result is dropped.
//   - If in_valid and flush are both high in the same cycle, the request is
//     NOT accepted; in_ready is forced low while flush=1.
//  Inputs are sampled only on accept; in_op/in_data may change otherwise.
//  out_zero is registered together with out_data on entry to DONE.
// STRUCTURE
//  - Package shift_pkg: typedef enum logic [1:0] shift_op_e
//    {SLL, SRL, SRA, ROR}; typedef enum state_e {IDLE, SHIFT, DONE};
//    function clog2-based helpers.
//  - Sub-module shift_step #(XLEN, STEP): purely combinational; shifts by
//    amt in 0..STEP for any op, with sign input for SRA. Instantiated once
//    in alu_shift_unit; the FSM, count and handshake registers live in
//    alu_shift_unit.
// TESTING
//  1. STEP=4, SLL in_data=32'h0000_0001 shamt=9
//     -> out_data=32'h0000_0200, out_valid 4 edges after accept,
//        out_zero=0.
//  2. STEP=4, SRA in_data=32'h8000_0000 shamt=31 -> out_data=32'hFFFF_FFFF;
//     SRL same operand/amount -> 32'h0000_0001.
//  3. STEP=1, ROR in_data=32'h0000_00F1 shamt=4 -> out_data=32'h1000_000F;
//     shamt=0 -> operand unchanged, L=2.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data
//     stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op
//     accepted the same cycle, next result correct.
//  5. Flush issued in SHIFT, and a separate flush in DONE -> out_valid=0
//     next cycle, state IDLE; flush+in_valid -> no accept.
//  6. Assert reset mid-SHIFT (asynchronously, between edges) -> all outputs
//     0 immediately; after release, SLL 32'hFFFF_FFFF shamt=31
//     -> 32'h8000_0000. Repeat random ops vs a reference model for
//     STEP in {1,4,32}.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ALU shifter.
//   shift_op_e : shift operation encoding seen on the request port
//   state_e    : sequencing states of alu_shift_unit
//   amt_width  : width needed to hold a per-cycle shift amount 0..step
package shift_pkg;

   typedef enum logic [1:0] {
      SLL = 2'd0,
      SRL = 2'd1,
      SRA = 2'd2,
      ROR = 2'd3
   } shift_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // The per-cycle amount must reach STEP itself, hence step + 1 codes.
   function automatic int amt_width(input int step);
      return $clog2(step + 1);
   endfunction

endpackage

// File: rtl/alu_shift_unit_if.sv
// Request/response bundle between the ALU issue logic (master) and the
// multi-cycle shifter (slave).
//   in_valid/in_ready/in_op/in_data/in_shamt : request handshake + operands
//   flush                                    : synchronous abort
//   out_valid/out_ready/out_data/out_zero    : result handshake + zero flag
//   busy                                     : unit not idle
interface alu_shift_unit_if #(
   parameter int XLEN = 32
) ();
   import shift_pkg::*;

   localparam int SHAMT_W = $clog2(XLEN);

   logic               in_valid;
   logic               in_ready;
   shift_op_e          in_op;
   logic [XLEN-1:0]    in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_data;
   logic               out_zero;
   logic               busy;

   modport master (
      output in_valid, in_op, in_data, in_shamt, flush, out_ready,
      input  in_ready, out_valid, out_data, out_zero, busy
   );

   modport slave (
      input  in_valid, in_op, in_data, in_shamt, flush, out_ready,
      output in_ready, out_valid, out_data, out_zero, busy
   );
endinterface

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits for any shift op.
//   op     : operation to apply
//   data   : current partial result
//   amt    : bits to shift this step (0..STEP)
//   sign   : fill bit for SRA (sign of the originally captured operand)
//   result : data shifted by amt
module shift_step
   import shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4,
   localparam int AMT_W = amt_width(STEP)
) (
   input  shift_op_e       op,
   input  logic [XLEN-1:0] data,
   input  logic [AMT_W-1:0] amt,
   input  logic            sign,
   output logic [XLEN-1:0] result
);

   // SRA and ROR shift a double-width word right and keep the low half:
   // the upper half supplies the fill bits (sign copies or the operand itself).
   always_comb begin
      result = data;
      case (op)
         SLL:     result = data << amt;
         SRL:     result = data >> amt;
         SRA:     result = XLEN'({{XLEN{sign}}, data} >> amt);
         ROR:     result = XLEN'({data, data} >> amt);
         default: result = data;
      endcase
   end

endmodule

// File: rtl/alu_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter moving up to STEP bits per cycle.
//   clk   : clock, rising edge
//   reset : asynchronous reset, active-high
//   bus   : slave side of alu_shift_unit_if (request, result, flush, busy)
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   SHIFT | applying min(cnt, STEP) bits per cycle until cnt is used up
//   DONE  | result held on out_data/out_zero until out_ready
module alu_shift_unit
   import shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4
) (
   input logic              clk,
   input logic              reset,
   alu_shift_unit_if.slave  bus
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam int AMT_W   = amt_width(STEP);

   state_e             state;
   shift_op_e          op_q;
   logic [XLEN-1:0]    data_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               sign_q;
   logic               out_valid_q;
   logic [XLEN-1:0]    out_data_q;
   logic               out_zero_q;

   logic               last_step;
   logic [AMT_W-1:0]   amt;
   logic [XLEN-1:0]    step_data;
   logic               accept;

   // One extra bit on the compare so STEP == XLEN still fits.
   assign last_step = {1'b0, cnt_q} <= (SHAMT_W + 1)'(STEP);
   assign amt       = last_step ? AMT_W'(cnt_q) : AMT_W'(STEP);

   assign bus.in_ready  = ~bus.flush &
                          ((state == IDLE) | ((state == DONE) & bus.out_ready));
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_zero  = out_zero_q;
   assign bus.busy      = (state != IDLE);

   shift_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_step (
      .op     (op_q),
      .data   (data_q),
      .amt    (amt),
      .sign   (sign_q),
      .result (step_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= SLL;
         data_q      <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_zero_q  <= 1'b0;
      end else if (bus.flush) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         // Reached from IDLE, or from DONE as the held result is consumed.
         state       <= SHIFT;
         op_q        <= bus.in_op;
         data_q      <= bus.in_data;
         cnt_q       <= bus.in_shamt;
         sign_q      <= bus.in_data[XLEN-1];
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               data_q <= step_data;
               if (last_step) begin
                  cnt_q       <= '0;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  out_data_q  <= step_data;
                  out_zero_q  <= (step_data == '0);
               end else begin
                  cnt_q <= cnt_q - SHAMT_W'(STEP);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_shift_unit.sv
module tb_alu_shift_unit;
   import shift_pkg::*;

   logic clk;
   logic reset;

   logic [2:0]  in_valid, in_ready, flush, out_valid, out_ready, out_zero, busy;
   logic [1:0]  in_op    [3];
   logic [31:0] in_data  [3];
   logic [4:0]  in_shamt [3];
   logic [31:0] out_data [3];

   int n_chk = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Three instances: serial (STEP=1), default (STEP=4), barrel (STEP=32).
   for (genvar g = 0; g < 3; g++) begin : g_dut
      alu_shift_unit_if #(.XLEN(32)) bus ();

      assign bus.in_valid  = in_valid[g];
      assign bus.in_op     = shift_op_e'(in_op[g]);
      assign bus.in_data   = in_data[g];
      assign bus.in_shamt  = in_shamt[g];
      assign bus.flush     = flush[g];
      assign bus.out_ready = out_ready[g];
      assign in_ready[g]   = bus.in_ready;
      assign out_valid[g]  = bus.out_valid;
      assign out_data[g]   = bus.out_data;
      assign out_zero[g]   = bus.out_zero;
      assign busy[g]       = bus.busy;

      alu_shift_unit #(
         .XLEN (32),
         .STEP ((g == 0) ? 1 : ((g == 1) ? 4 : 32))
      ) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   function automatic int step_of(input int sel);
      return (sel == 0) ? 1 : ((sel == 1) ? 4 : 32);
   endfunction

   // Whole-amount reference: one shift by shamt, no stepping involved.
   function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                             input logic [31:0] d,
                                             input logic [4:0] sh);
      logic [63:0] w;
      case (op)
         2'd0:    return d << sh;
         2'd1:    return d >> sh;
         2'd2:    return $signed(d) >>> sh;
         default: begin
            w = {d, d} >> sh;
            return w[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input int sel, input logic [4:0] sh);
      int st, n;
      st = step_of(sel);
      n  = (int'(sh) + st - 1) / st;
      return 1 + ((n < 1) ? 1 : n);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int sel, input logic [1:0] op,
                        input logic [31:0] d, input logic [4:0] sh);
      in_valid[sel] = 1'b1;
      in_op[sel]    = op;
      in_data[sel]  = d;
      in_shamt[sel] = sh;
   endtask

   // Edge that samples the request; operands are scrambled afterwards.
   task automatic accept_edge(input int sel);
      tick();
      in_valid[sel] = 1'b0;
      in_data[sel]  = $urandom;
      in_op[sel]    = 2'($urandom_range(0, 3));
      in_shamt[sel] = 5'($urandom_range(0, 31));
   endtask

   // Latency counts the accept edge as 1.
   task automatic collect(input int sel, input logic [1:0] op,
                          input logic [31:0] d, input logic [4:0] sh,
                          input string tag);
      int lat;
      logic [31:0] exp;
      lat = 1;
      while (!out_valid[sel] && lat < 40) begin
         tick();
         lat++;
      end
      exp = ref_shift(op, d, sh);
      chk($sformatf("%s lat", tag), 32'(lat), 32'(ref_lat(sel, sh)));
      chk($sformatf("%s data", tag), out_data[sel], exp);
      chk($sformatf("%s zero", tag), {31'd0, out_zero[sel]}, {31'd0, exp == 32'd0});
   endtask

   task automatic run_op(input int sel, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] sh,
                         input string tag);
      out_ready[sel] = 1'b1;
      issue(sel, op, d, sh);
      accept_edge(sel);
      collect(sel, op, d, sh, tag);
      tick();
   endtask

   initial begin
      logic [31:0] held;
      reset     = 1'b1;
      in_valid  = '0;
      flush     = '0;
      out_ready = '0;
      for (int s = 0; s < 3; s++) begin
         in_op[s]    = 2'd0;
         in_data[s]  = 32'd0;
         in_shamt[s] = 5'd0;
      end
      #22 reset = 1'b0;
      tick();
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst%0d out_valid", s), {31'd0, out_valid[s]}, 32'd0);
         chk($sformatf("rst%0d out_data", s), out_data[s], 32'd0);
         chk($sformatf("rst%0d out_zero", s), {31'd0, out_zero[s]}, 32'd0);
         chk($sformatf("rst%0d busy", s), {31'd0, busy[s]}, 32'd0);
         chk($sformatf("rst%0d in_ready", s), {31'd0, in_ready[s]}, 32'd1);
      end

      // Directed cases.
      run_op(1, 2'd0, 32'h0000_0001, 5'd9,  "s4_sll9");
      run_op(1, 2'd2, 32'h8000_0000, 5'd31, "s4_sra31");
      run_op(1, 2'd1, 32'h8000_0000, 5'd31, "s4_srl31");
      run_op(1, 2'd1, 32'h0000_0001, 5'd1,  "s4_srl_zero");
      run_op(0, 2'd3, 32'h0000_00F1, 5'd4,  "s1_ror4");
      run_op(0, 2'd3, 32'h0000_00F1, 5'd0,  "s1_ror0");
      run_op(2, 2'd2, 32'h9000_0000, 5'd31, "s32_sra31");
      run_op(2, 2'd3, 32'h1234_5678, 5'd12, "s32_ror12");

      // Backpressure then back-to-back issue in the releasing cycle.
      out_ready[1] = 1'b0;
      issue(1, 2'd0, 32'h0000_00A5, 5'd5);
      accept_edge(1);
      collect(1, 2'd0, 32'h0000_00A5, 5'd5, "bp_first");
      held = ref_shift(2'd0, 32'h0000_00A5, 5'd5);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp hold%0d data", i), out_data[1], held);
         chk($sformatf("bp hold%0d valid", i), {31'd0, out_valid[1]}, 32'd1);
         chk($sformatf("bp hold%0d in_ready", i), {31'd0, in_ready[1]}, 32'd0);
      end
      out_ready[1] = 1'b1;
      issue(1, 2'd3, 32'h1234_5678, 5'd8);
      #1 chk("bp release in_ready", {31'd0, in_ready[1]}, 32'd1);
      accept_edge(1);
      chk("bp b2b valid_low", {31'd0, out_valid[1]}, 32'd0);
      chk("bp b2b busy", {31'd0, busy[1]}, 32'd1);
      collect(1, 2'd3, 32'h1234_5678, 5'd8, "bp_second");
      tick();

      // Flush while shifting.
      out_ready[0] = 1'b1;
      issue(0, 2'd0, 32'h0000_0003, 5'd20);
      accept_edge(0);
      tick();
      tick();
      flush[0] = 1'b1;
      tick();
      flush[0] = 1'b0;
      chk("flush_shift valid", {31'd0, out_valid[0]}, 32'd0);
      chk("flush_shift busy", {31'd0, busy[0]}, 32'd0);
      for (int i = 0; i < 25; i++) tick();
      chk("flush_shift no_result", {31'd0, out_valid[0]}, 32'd0);

      // Flush while holding a result.
      out_ready[1] = 1'b0;
      issue(1, 2'd1, 32'hF000_0000, 5'd4);
      accept_edge(1);
      collect(1, 2'd1, 32'hF000_0000, 5'd4, "flush_done_pre");
      flush[1] = 1'b1;
      tick();
      flush[1] = 1'b0;
      chk("flush_done valid", {31'd0, out_valid[1]}, 32'd0);
      chk("flush_done busy", {31'd0, busy[1]}, 32'd0);

      // Flush together with a request: must not be taken.
      flush[1] = 1'b1;
      issue(1, 2'd0, 32'h0000_0001, 5'd3);
      #1 chk("flush_req in_ready", {31'd0, in_ready[1]}, 32'd0);
      tick();
      in_valid[1] = 1'b0;
      flush[1]    = 1'b0;
      chk("flush_req busy", {31'd0, busy[1]}, 32'd0);
      tick();
      chk("flush_req no_result", {31'd0, out_valid[1]}, 32'd0);
      run_op(1, 2'd0, 32'h0000_0001, 5'd3, "post_flush");

      // Asynchronous reset in the middle of a shift.
      out_ready[0] = 1'b1;
      issue(0, 2'd0, 32'h0000_0005, 5'd30);
      accept_edge(0);
      tick();
      tick();
      #3 reset = 1'b1;
      #1;
      chk("async_rst valid", {31'd0, out_valid[0]}, 32'd0);
      chk("async_rst busy", {31'd0, busy[0]}, 32'd0);
      chk("async_rst data", out_data[0], 32'd0);
      chk("async_rst zero", {31'd0, out_zero[0]}, 32'd0);
      chk("async_rst data_s4", out_data[1], 32'd0);
      #2 reset = 1'b0;
      tick();
      for (int s = 0; s < 3; s++)
         run_op(s, 2'd0, 32'hFFFF_FFFF, 5'd31, $sformatf("post_rst%0d", s));

      // Random operations against the reference model.
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            logic [4:0]  sh;
            op = 2'($urandom_range(0, 3));
            d  = (i % 8 == 7) ? 32'd0 : $urandom;
            sh = (i % 10 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            run_op(s, op, d, sh, $sformatf("rnd s%0d i%0d op%0d sh%0d", s, i, op, sh));
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
